vip_frame_sequencer: RTL and testbench
======================================

// Module: vip_frame_sequencer
// PURPOSE
//  Sits between the sensor capture port and the Bayer-to-RGB demosaic stage of the video image processor.
//  - Admits only whole frames. A frame is admitted only if this block sees its vsync rising edge.
//  - Applies frame decimation and enforces the IMG_HDISP x IMG_VDISP geometry.
//  - After each admitted frame, injects FLUSH_LINES dummy lines so the demosaic line buffers drain the last real rows.
// PARAMETERS
//  IMG_HDISP    13'd640  active pixels per line
//  IMG_VDISP    13'd480  active lines per frame
//  DATA_W       5'd8     RAW pixel width
//  FLUSH_LINES  2        dummy lines appended per frame (1..3)
//  HBLANK       16       idle cycles before and between flush lines (>=2)
// PORTS
//  clk               in   1       pixel clock
//  rst_n             in   1       async active-low reset
//  pre_frame_vsync   in   1       input frame valid (high for whole frame)
//  pre_frame_href    in   1       input line valid
//  pre_img_data      in   DATA_W  input RAW pixel
//  cfg_enable        in   1       admit frames when 1
//  cfg_skip          in   4       pass 1 frame, then drop cfg_skip frames
//  seq_frame_vsync   out  1       vsync to demosaic
//  seq_frame_href    out  1       href to demosaic
//  seq_img_data      out  DATA_W  pixel to demosaic
//  busy              out  1       state != IDLE
//  frame_cnt         out  16      admitted-frame counter, wraps
//  err_hlen          out  1       sticky: line length != IMG_HDISP
//  err_vlen          out  1       sticky: line count != IMG_VDISP
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, skip counter 0.
//  - Outputs registered; data path latency 1 clk (pre_* at cycle n -> seq_* at n+1).
//  - States:
//    - IDLE: on vsync rising edge with cfg_enable=1:
//      - skip counter == 0 -> ACTIVE; reload skip counter from cfg_skip.
//      - otherwise decrement skip counter -> DROP.
//    - DROP: seq_* held 0; return to IDLE on vsync falling edge.
//    - ACTIVE: seq_frame_vsync=1.
//      - href/data forwarded only while hcnt < IMG_HDISP and vcnt < IMG_VDISP. Excess pixels/lines suppressed.
//      - hcnt clears on href falling edge; vcnt increments on each href falling edge.
//      - Exits on vsync falling edge -> FLUSH.
//    - FLUSH:
//      - Vsync stays 1.
//      - HBLANK idle cycles, then IMG_HDISP cycles of href=1 with data=0; repeat FLUSH_LINES times.
//      - After a final HBLANK -> IDLE. Vsync drops on the IDLE transition; frame_cnt increments on that same edge.
//  - cfg_enable/cfg_skip are sampled only at the vsync rising edge in IDLE. Mid-frame changes take effect next frame.
//  - err_hlen set on any href fall in ACTIVE with hcnt != IMG_HDISP (short or long).
//  - err_vlen set on vsync fall with vcnt != IMG_VDISP. Flush still runs on short frames.
//  - A vsync rising edge during DROP-exit or FLUSH is ignored. That frame is lost: not admitted, not counted.
//  - A frame already in progress at reset release, or when cfg_enable rises, is not admitted; wait for the next vsync rising edge.
//  - Async reset mid-frame: immediate return to reset values, no flush.
//  - hcnt/vcnt 13 bit and saturate at 8191. frame_cnt wraps 65535 -> 0.
// CONFIGURATION
//  VIP_SEQ_ERR_EN:
//  - Defined: err_hlen/err_vlen logic present. Flags clear only on rst_n or on a rising edge of cfg_enable.
//  - Undefined: error logic is not built and err_hlen=err_vlen=0. Sequencing is identical.
// STRUCTURE
//  - vip_defs.vh (shared): state encodings (IDLE, DROP, ACTIVE, FLUSH), counter width localparams, frame_cnt width.
//  - Sub-module vip_flush_gen: generates the FLUSH href/data pattern from start/done.
//  - Parent holds the FSM, edge detectors, counters and error flags.
// TESTING
//  Default bench parameters: HDISP=8, VDISP=4, FLUSH_LINES=2, HBLANK=4, macro defined.
//  1. Clean frame (4 lines x 8 px, skip=0) -> 32 px forwarded at 1 clk latency, then 2 zero lines of 8 px;
//     seq vsync falls after the last HBLANK; frame_cnt=1; no error flags.
//  2. skip=2, 6 input frames -> frames 1 and 4 admitted; frame_cnt=2; seq_* stay 0 during frames 2, 3, 5, 6.
//  3. Line 2 with 10 px -> px 9-10 suppressed; err_hlen=1. Frame with 3 lines -> 2 flush lines still emitted; err_vlen=1.
//  4. cfg_enable raised mid-frame -> that frame dropped, next frame admitted.
//     Vsync rises during FLUSH -> that frame ignored, frame_cnt unchanged.
//  5. rst_n low during line 2 -> all outputs 0 within the same cycle; after release, a mid-frame href is not forwarded.
//  6. Macro undefined, repeat scenario 3 -> both error flags stay 0; pixel stream identical.

Source files
------------

// File: rtl/vip_frame_sequencer_pkg.sv
// Shared types for the frame sequencer: FSM states, counter widths, saturating increment.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vip_frame_sequencer_pkg;

  localparam int CNT_W       = 13;
  localparam int FRAME_CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DROP   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FLUSH  = 2'd3
  } seq_state_t;

  // Line/pixel counters stick at all-ones instead of wrapping on runaway input.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vip_frame_sequencer_if.sv
// Video stream bundle: vsync, href and RAW pixel; master drives, slave observes.
// Latency: n/a (wires only).
// Backpressure: none, the pixel clock stream cannot be stalled.
interface vip_frame_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              frame_vsync;
  logic              frame_href;
  logic [DATA_W-1:0] img_data;

  modport master (output frame_vsync, frame_href, img_data);
  modport slave  (input  frame_vsync, frame_href, img_data);
endinterface

// File: rtl/vip_frame_sequencer_flush_gen.sv
// Dummy-line generator: after start, HBLANK idle / IMG_HDISP href cycles, FLUSH_LINES times, then a final HBLANK.
// Latency: the start cycle itself is the first idle cycle; done pulses one cycle after the final idle run.
// Backpressure: none, free-running once started.
module vip_frame_sequencer_flush_gen #(
  parameter logic [12:0] IMG_HDISP   = 13'd640,
  parameter int          FLUSH_LINES = 2,
  parameter int          HBLANK      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic href,
  output logic done
);

  localparam logic [15:0] HBLANK_C = 16'(HBLANK);
  localparam logic [15:0] HDISP_C  = 16'(IMG_HDISP);
  localparam logic [1:0]  LINES_C  = 2'(FLUSH_LINES);

  logic        running;
  logic        in_line;
  logic [15:0] cnt;
  logic [1:0]  line;
  logic        last_blank;

  assign last_blank = (line == LINES_C);
  assign href       = running & in_line;
  // The final blank run counts one cycle further so the parent drops vsync after a full HBLANK.
  assign done       = running & ~in_line & last_blank & (cnt == HBLANK_C);

  // Segment sequencer: blank -> line -> blank ... -> final blank -> stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      in_line <= 1'b0;
      cnt     <= '0;
      line    <= '0;
    end else if (start) begin
      running <= 1'b1;
      in_line <= 1'b0;
      cnt     <= 16'd1;
      line    <= '0;
    end else if (running) begin
      if (in_line) begin
        if (cnt == HDISP_C - 16'd1) begin
          in_line <= 1'b0;
          cnt     <= '0;
          line    <= line + 2'd1;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else if (last_blank) begin
        if (cnt == HBLANK_C) begin
          running <= 1'b0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else if (cnt == HBLANK_C - 16'd1) begin
        in_line <= 1'b1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/vip_frame_sequencer.sv
// Admits whole frames (decimated by cfg_skip), crops to IMG_HDISP x IMG_VDISP, appends flush lines; VIP_SEQ_ERR_EN builds the geometry error flags.
// Latency: 1 clk from pre to seq on the pixel path.
// Backpressure: none, dropped or excess pixels are discarded.
module vip_frame_sequencer
  import vip_frame_sequencer_pkg::*;
#(
  parameter logic [12:0] IMG_HDISP   = 13'd640,
  parameter logic [12:0] IMG_VDISP   = 13'd480,
  parameter int          DATA_W      = 8,
  parameter int          FLUSH_LINES = 2,
  parameter int          HBLANK      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  vip_frame_sequencer_if.slave     pre,
  vip_frame_sequencer_if.master    seq,
  input  logic                     cfg_enable,
  input  logic [3:0]               cfg_skip,
  output logic                     busy,
  output logic [FRAME_CNT_W-1:0]   frame_cnt,
  output logic                     err_hlen,
  output logic                     err_vlen
);

  seq_state_t        state, state_nxt;
  logic              vsync_d, href_d;
  logic              vs_rise, vs_fall, href_fall;
  logic              admit, flush_start, flush_href, flush_done;
  logic [3:0]        skip_cnt;
  logic [CNT_W-1:0]  hcnt, vcnt;
  logic              in_geom;
  logic              vsync_r, href_r;
  logic [DATA_W-1:0] data_r;

  assign vs_rise   = pre.frame_vsync & ~vsync_d;
  assign vs_fall   = ~pre.frame_vsync & vsync_d;
  assign href_fall = ~pre.frame_href & href_d;
  assign in_geom   = (hcnt < IMG_HDISP) && (vcnt < IMG_VDISP);
  assign busy      = (state != ST_IDLE);

  assign seq.frame_vsync = vsync_r;
  assign seq.frame_href  = href_r;
  assign seq.img_data    = data_r;

  vip_frame_sequencer_flush_gen #(
    .IMG_HDISP   (IMG_HDISP),
    .FLUSH_LINES (FLUSH_LINES),
    .HBLANK      (HBLANK)
  ) u_flush_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .start (flush_start),
    .href  (flush_href),
    .done  (flush_done)
  );

  // Edge detectors; vsync_d resets high so a frame already running at reset release shows no rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b1;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= pre.frame_vsync;
      href_d  <= pre.frame_href;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: only IDLE looks at vsync rising, so rises during DROP or FLUSH are lost.
  always_comb begin
    state_nxt   = state;
    admit       = 1'b0;
    flush_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vs_rise && cfg_enable) begin
          if (skip_cnt == 4'd0) begin
            state_nxt = ST_ACTIVE;
            admit     = 1'b1;
          end else begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_DROP:   if (vs_fall) state_nxt = ST_IDLE;
      ST_ACTIVE: begin
        if (vs_fall) begin
          state_nxt   = ST_FLUSH;
          flush_start = 1'b1;
        end
      end
      ST_FLUSH:  if (flush_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Decimation: reload on an admitted frame, count down on each skipped one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt <= '0;
    end else if (state == ST_IDLE && vs_rise && cfg_enable) begin
      skip_cnt <= (skip_cnt == 4'd0) ? cfg_skip : skip_cnt - 4'd1;
    end
  end

  // Geometry counters: pixels within the line, lines within the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (admit) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (state == ST_ACTIVE) begin
      if (href_fall) begin
        hcnt <= '0;
        vcnt <= sat_inc(vcnt);
      end else if (pre.frame_href) begin
        hcnt <= sat_inc(hcnt);
      end
    end
  end

  // Registered output stream: cropped input while ACTIVE, flush pattern while FLUSH, zeros otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
      data_r  <= '0;
    end else begin
      vsync_r <= (state_nxt == ST_ACTIVE) || (state_nxt == ST_FLUSH);
      if (state == ST_ACTIVE) begin
        href_r <= in_geom & pre.frame_href;
        data_r <= (in_geom && pre.frame_href) ? pre.img_data : '0;
      end else if (state == ST_FLUSH) begin
        href_r <= flush_href;
        data_r <= '0;
      end else begin
        href_r <= 1'b0;
        data_r <= '0;
      end
    end
  end

  // Admitted-frame counter, stepped on the same edge vsync drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             frame_cnt <= '0;
    else if (state == ST_FLUSH && flush_done) frame_cnt <= frame_cnt + 1'b1;
  end

`ifdef VIP_SEQ_ERR_EN
  logic             cfg_enable_d;
  logic [CNT_W-1:0] vcnt_end;

  // A line closing on the same cycle as vsync still counts toward the frame.
  assign vcnt_end = href_fall ? sat_inc(vcnt) : vcnt;

  // Sticky geometry flags; re-enabling the block clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_enable_d <= 1'b0;
      err_hlen     <= 1'b0;
      err_vlen     <= 1'b0;
    end else begin
      cfg_enable_d <= cfg_enable;
      if (cfg_enable && !cfg_enable_d) begin
        err_hlen <= 1'b0;
        err_vlen <= 1'b0;
      end else begin
        if (state == ST_ACTIVE && href_fall && hcnt != IMG_HDISP) err_hlen <= 1'b1;
        if (state == ST_ACTIVE && vs_fall && vcnt_end != IMG_VDISP) err_vlen <= 1'b1;
      end
    end
  end
`else
  assign err_hlen = 1'b0;
  assign err_vlen = 1'b0;
`endif

endmodule

// File: tb/tb_vip_frame_sequencer.sv
// Bench for vip_frame_sequencer: drives RAW frames, scoreboards every forwarded and flush pixel with its arrival cycle.
// Latency: expects seq pixel one cycle after the pre pixel.
// Backpressure: none.
`timescale 1ns/1ps
module tb_vip_frame_sequencer;

  localparam int HD = 8;
  localparam int VD = 4;
  localparam int FL = 2;
  localparam int HB = 4;
  localparam int DW = 8;

  logic        clk;
  logic        rst_n;
  logic        cfg_enable;
  logic [3:0]  cfg_skip;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_hlen;
  logic        err_vlen;

  vip_frame_sequencer_if #(.DATA_W(DW)) pre_if ();
  vip_frame_sequencer_if #(.DATA_W(DW)) seq_if ();

  vip_frame_sequencer #(
    .IMG_HDISP   (13'(HD)),
    .IMG_VDISP   (13'(VD)),
    .DATA_W      (DW),
    .FLUSH_LINES (FL),
    .HBLANK      (HB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pre        (pre_if),
    .seq        (seq_if),
    .cfg_enable (cfg_enable),
    .cfg_skip   (cfg_skip),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .err_hlen   (err_hlen),
    .err_vlen   (err_vlen)
  );

  typedef struct {
    logic [7:0] dat;
    int         cyc;
  } exp_px_t;

  exp_px_t sb[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      exp_fall_cyc = -1;
  int      exp_fcnt = 0;
  bit      exp_hlen = 0;
  bit      exp_vlen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every href must match the head of the scoreboard, in value and in cycle.
  always @(negedge clk) begin
    if (seq_if.frame_href) begin
      if (sb.size() == 0) begin
        chk("unexp_href", 32'(seq_if.frame_href), 32'd0);
      end else begin
        exp_px_t e;
        e = sb.pop_front();
        chk("px_dat", 32'(seq_if.img_data), 32'(e.dat));
        chk("px_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
    if (exp_fall_cyc >= 0) begin
      if (cyc == exp_fall_cyc - 1) chk("vs_hold", 32'(seq_if.frame_vsync), 32'd1);
      if (cyc == exp_fall_cyc) begin
        chk("vs_fall", 32'(seq_if.frame_vsync), 32'd0);
        exp_fcnt++;
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
        chk("busy_end", 32'(busy), 32'd0);
        exp_fall_cyc = -1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit vs, input bit hr, input logic [7:0] d);
    @(negedge clk);
    pre_if.frame_vsync = vs;
    pre_if.frame_href  = hr;
    pre_if.img_data    = d;
  endtask

  task automatic check_flags();
`ifdef VIP_SEQ_ERR_EN
    chk("err_hlen", 32'(err_hlen), 32'(exp_hlen));
    chk("err_vlen", 32'(err_vlen), 32'(exp_vlen));
`else
    chk("err_hlen", 32'(err_hlen), 32'd0);
    chk("err_vlen", 32'(err_vlen), 32'd0);
`endif
  endtask

  // One frame: 3 lead cycles, nlines lines with 3-cycle gaps, line bad_line is bad_len pixels long.
  task automatic drive_frame(input int nlines, input int bad_line, input int bad_len,
                             input bit admit, input bit en_mid, input bit vs_mid_exp);
    int         len;
    logic [7:0] px;
    bit         hl;
    hl = 0;
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    for (int l = 0; l < nlines; l++) begin
      len = (l == bad_line) ? bad_len : HD;
      if (len != HD) hl = 1;
      for (int p = 0; p < len; p++) begin
        px = 8'($urandom);
        drive(1'b1, 1'b1, px);
        if (admit && p < HD && l < VD) sb.push_back('{px, cyc + 1});
      end
      repeat (3) drive(1'b1, 1'b0, 8'h00);
      if (l == 0) begin
        chk("vs_mid", 32'(seq_if.frame_vsync), 32'(vs_mid_exp));
        if (en_mid) begin
          cfg_enable = 1'b1;
          exp_hlen   = 0;
          exp_vlen   = 0;
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    if (admit) begin
      for (int ln = 0; ln < FL; ln++)
        for (int j = 0; j < HD; j++)
          sb.push_back('{8'h00, cyc + HB * (ln + 1) + HD * ln + 1 + j});
      exp_fall_cyc = cyc + (FL + 1) * HB + FL * HD + 1;
      if (hl) exp_hlen = 1;
      if (nlines != VD) exp_vlen = 1;
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    cfg_enable         = 1'b0;
    cfg_skip           = 4'd0;
    pre_if.frame_vsync = 1'b0;
    pre_if.frame_href  = 1'b0;
    pre_if.img_data    = '0;
    idle(3);
    chk("rst_vsync", 32'(seq_if.frame_vsync), 32'd0);
    chk("rst_href",  32'(seq_if.frame_href),  32'd0);
    chk("rst_data",  32'(seq_if.img_data),    32'd0);
    chk("rst_busy",  32'(busy),               32'd0);
    chk("rst_fcnt",  32'(frame_cnt),          32'd0);
    chk("rst_hlen",  32'(err_hlen),           32'd0);
    chk("rst_vlen",  32'(err_vlen),           32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cfg_enable = 1'b1;
    idle(3);

    // Clean frame.
    drive_frame(4, -1, 0, 1'b1, 1'b0, 1'b1);
    idle(35);
    check_flags();

    // Decimation: pass one, drop two.
    cfg_skip = 4'd2;
    for (int f = 0; f < 6; f++) begin
      drive_frame(4, -1, 0, (f == 0 || f == 3), 1'b0, (f == 0 || f == 3));
      idle(35);
    end
    cfg_skip = 4'd0;
    chk("fcnt_skip", 32'(frame_cnt), 32'(exp_fcnt));

    // Long line, then short frame; flags sticky until cfg_enable rises again.
    drive_frame(4, 1, 10, 1'b1, 1'b0, 1'b1);
    idle(35);
    check_flags();
    drive_frame(3, -1, 0, 1'b1, 1'b0, 1'b1);
    idle(35);
    check_flags();
    cfg_enable = 1'b0;
    idle(2);
    cfg_enable = 1'b1;
    exp_hlen   = 0;
    exp_vlen   = 0;
    idle(2);
    check_flags();

    // Enable raised mid-frame, then a frame whose vsync rises during flush.
    cfg_enable = 1'b0;
    idle(2);
    drive_frame(4, -1, 0, 1'b0, 1'b1, 1'b0);
    idle(35);
    drive_frame(4, -1, 0, 1'b1, 1'b0, 1'b1);
    idle(5);
    drive_frame(4, -1, 0, 1'b0, 1'b0, 1'b1);
    idle(35);
    chk("fcnt_lost", 32'(frame_cnt), 32'(exp_fcnt));
    check_flags();

    // Asynchronous reset during line 2.
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    for (int p = 0; p < HD; p++) begin
      logic [7:0] px;
      px = 8'($urandom);
      drive(1'b1, 1'b1, px);
      sb.push_back('{px, cyc + 1});
    end
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    for (int p = 0; p < 3; p++) begin
      logic [7:0] px;
      px = 8'($urandom);
      drive(1'b1, 1'b1, px);
      sb.push_back('{px, cyc + 1});
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vsync", 32'(seq_if.frame_vsync), 32'd0);
    chk("arst_href",  32'(seq_if.frame_href),  32'd0);
    chk("arst_data",  32'(seq_if.img_data),    32'd0);
    chk("arst_busy",  32'(busy),               32'd0);
    chk("arst_fcnt",  32'(frame_cnt),          32'd0);
    chk("arst_hlen",  32'(err_hlen),           32'd0);
    chk("arst_vlen",  32'(err_vlen),           32'd0);
    sb.delete();
    exp_fall_cyc = -1;
    exp_fcnt     = 0;
    exp_hlen     = 0;
    exp_vlen     = 0;
    idle(2);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int p = 3; p < HD; p++) drive(1'b1, 1'b1, 8'($urandom));
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    chk("post_rst_vsync", 32'(seq_if.frame_vsync), 32'd0);
    chk("post_rst_busy",  32'(busy),               32'd0);
    for (int l = 2; l < VD; l++) begin
      for (int p = 0; p < HD; p++) drive(1'b1, 1'b1, 8'($urandom));
      repeat (3) drive(1'b1, 1'b0, 8'h00);
    end
    drive(1'b0, 1'b0, 8'h00);
    idle(10);

    // Recovery frame after reset.
    drive_frame(4, -1, 0, 1'b1, 1'b0, 1'b1);
    idle(35);
    check_flags();

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
